// File: rtl/clock_divider_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clock_divider_pkg;

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUNNING  = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam int MIN_DIV = 2;

  // High-phase length in source cycles; DIV_WIDTH is limited to 32 by this helper.
  function automatic logic [31:0] half_period(input logic [31:0] n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/clock_divider_counter.sv
// Period counter: wraps at div_active-1, and reports whether the next cycle is in the high phase.
module clock_divider_counter
  import clock_divider_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 count_en,
  input  logic [DIV_WIDTH-1:0] div_active,
  output logic                 wrap,
  output logic                 high_phase
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] cnt_nxt;

  assign wrap = (cnt == div_active - DIV_WIDTH'(1));

  always_comb begin
    cnt_nxt = cnt;
    if (clear)         cnt_nxt = '0;
    else if (count_en) cnt_nxt = wrap ? '0 : cnt + DIV_WIDTH'(1);
  end

  // Looks at the upcoming count so the registered clk_out lines up with cnt.
  // Ratio changes only happen where cnt_nxt is 0, which is high for any N >= 2.
  assign high_phase = (32'(cnt_nxt) < half_period(32'(div_active)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

endmodule

// File: rtl/clock_divider_ctrl.sv
// Programmable clock divider with boundary-aligned ratio reload and glitch-free start/stop.
// Optional CLKDIV_ODD_DUTY50_EN adds a falling-edge stage giving 50% duty for odd ratios.
module clock_divider_ctrl
  import clock_divider_pkg::*;
#(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 div_load,
  output logic                 div_ack,
  output logic                 div_err,
  output logic                 clk_out,
  output logic                 tick,
  output logic                 running,
  output logic [DIV_WIDTH-1:0] div_active
);

  state_t               state, state_nxt;
  logic [DIV_WIDTH-1:0] pending_div;
  logic                 pending_valid;
  logic                 pos_q;
  logic                 wrap;
  logic                 high_phase;
  logic                 load_ok;
  logic                 load_bad;
  logic                 apply;

  clock_divider_counter #(.DIV_WIDTH(DIV_WIDTH)) u_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == STOPPED),
    .count_en   (state != STOPPED),
    .div_active (div_active),
    .wrap       (wrap),
    .high_phase (high_phase)
  );

  assign load_ok  = div_load && (div_value >= DIV_WIDTH'(MIN_DIV));
  assign load_bad = div_load && !load_ok;
  // A load landing on the boundary itself is applied directly, bypassing pending.
  assign apply    = ((state == STOPPED) || wrap) && (pending_valid || load_ok);
  assign running  = (state != STOPPED);
  assign tick     = wrap && (state != STOPPED);

  always_comb begin
    state_nxt = state;
    case (state)
      STOPPED:  if (enable) state_nxt = RUNNING;
      RUNNING:  if (!enable) state_nxt = wrap ? STOPPED : STOPPING;
      STOPPING: if (wrap) state_nxt = enable ? RUNNING : STOPPED;
      default:  state_nxt = STOPPED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= STOPPED;
      pos_q         <= 1'b0;
      div_ack       <= 1'b0;
      div_err       <= 1'b0;
      div_active    <= DIV_WIDTH'(DEFAULT_DIV);
      pending_div   <= DIV_WIDTH'(DEFAULT_DIV);
      pending_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      pos_q   <= high_phase && (state_nxt != STOPPED);
      div_ack <= apply;
      div_err <= load_bad;
      if (apply) begin
        div_active    <= load_ok ? div_value : pending_div;
        pending_valid <= 1'b0;
      end else if (load_ok) begin
        pending_div   <= div_value;
        pending_valid <= 1'b1;
      end
    end
  end

`ifdef CLKDIV_ODD_DUTY50_EN
  // Half-cycle extension of the high phase, only for odd ratios.
  logic neg_q;
  always_ff @(negedge clk or posedge rst) begin
    if (rst) neg_q <= 1'b0;
    else     neg_q <= pos_q & div_active[0];
  end
  assign clk_out = pos_q | neg_q;
`else
  assign clk_out = pos_q;
`endif

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Directed checks of clock_divider_ctrl: start, reload, bad loads, stop/restart, async reset, duty.
module tb_clock_divider_ctrl;

  localparam int DW = 16;

  logic          clk, rst, enable, div_load;
  logic [DW-1:0] div_value;
  logic          div_ack, div_err, clk_out, tick, running;
  logic [DW-1:0] div_active;

  int errors = 0;
  int checks = 0;

  clock_divider_ctrl #(.DIV_WIDTH(DW), .DEFAULT_DIV(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .div_value  (div_value),
    .div_load   (div_load),
    .div_ack    (div_ack),
    .div_err    (div_err),
    .clk_out    (clk_out),
    .tick       (tick),
    .running    (running),
    .div_active (div_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advance until a sample shows tick, with a bounded budget.
  task automatic sync_tick();
    int n;
    n = 0;
    cyc();
    while (tick !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    chk("sync_tick", tick, 1);
  endtask

  initial begin
    logic [6:0] v2_clk, v2_tick, v2_ack;
    logic [5:0] v5_clk, v5_run, v5_tick;
    logic [4:0] v5b_clk, v5b_tick;
    int  n, acks, hi, tk;
    longint t0, t1;

    rst = 1'b1; enable = 1'b0; div_load = 1'b0; div_value = '0;
    cyc();
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_ack", div_ack, 0);
    chk("rst_err", div_err, 0);
    chk("rst_running", running, 0);
    chk("rst_div_active", div_active, 2);
    rst = 1'b0;
    cyc();
    chk("idle_running", running, 0);

    // 1: default N=2 start
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t1_clk", clk_out, (i % 2 == 0) ? 1 : 0);
      chk("t1_tick", tick, (i % 2 == 1) ? 1 : 0);
      chk("t1_running", running, 1);
    end

    // 2: load N=5 at cnt0 of N=2
    v2_tick = 7'b1000010;
    v2_ack  = 7'b0100000;
`ifdef CLKDIV_ODD_DUTY50_EN
    v2_clk  = 7'b0111001;
`else
    v2_clk  = 7'b0110001;
`endif
    div_load = 1'b1; div_value = 16'd5;
    for (int i = 0; i < 7; i++) begin
      cyc();
      div_load = 1'b0;
      chk("t2_clk", clk_out, v2_clk[6-i]);
      chk("t2_tick", tick, v2_tick[6-i]);
      chk("t2_ack", div_ack, v2_ack[6-i]);
    end
    chk("t2_div_active", div_active, 5);

    // 3: load coincident with a wrap, then two loads in one N=10 period
    sync_tick();
    div_load = 1'b1; div_value = 16'd10;
    cyc();
    div_load = 1'b0;
    chk("t3_coinc_ack", div_ack, 1);
    chk("t3_coinc_div", div_active, 10);
    cyc();
    div_load = 1'b1; div_value = 16'd8;
    cyc();
    div_load = 1'b0;
    cyc();
    div_load = 1'b1; div_value = 16'd6;
    cyc();
    div_load = 1'b0;
    acks = 0; n = 0;
    while (tick !== 1'b1 && n < 20) begin
      cyc();
      acks += int'(div_ack);
      n++;
    end
    chk("t3_no_early_ack", acks, 0);
    chk("t3_wrap10", n, 5);
    cyc();
    chk("t3_ack", div_ack, 1);
    chk("t3_div_active", div_active, 6);
    n = 0;
    do begin
      cyc();
      n++;
    end while (tick !== 1'b1 && n < 20);
    chk("t3_gap6", n, 5);

    // 4: illegal ratios
    div_load = 1'b1; div_value = 16'd1;
    cyc();
    div_load = 1'b0;
    chk("t4_err1", div_err, 1);
    chk("t4_ack1", div_ack, 0);
    cyc();
    chk("t4_err1_clr", div_err, 0);
    div_load = 1'b1; div_value = 16'd0;
    cyc();
    div_load = 1'b0;
    chk("t4_err0", div_err, 1);
    cyc();
    chk("t4_err0_clr", div_err, 0);
    chk("t4_div_active", div_active, 6);
    sync_tick();
    hi = 0; tk = 0; acks = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      hi += int'(clk_out);
      tk += int'(tick);
      acks += int'(div_ack);
    end
    chk("t4_high", hi, 3);
    chk("t4_ticks", tk, 1);
    chk("t4_no_ack", acks, 0);

    // 5: stop at cnt1 of N=6, restart, then re-enable inside STOPPING
    v5_clk  = 6'b100000;
    v5_run  = 6'b111100;
    v5_tick = 6'b000100;
    cyc();
    cyc();
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t5_clk", clk_out, v5_clk[5-i]);
      chk("t5_run", running, v5_run[5-i]);
      chk("t5_tick", tick, v5_tick[5-i]);
    end
    enable = 1'b1;
    cyc();
    chk("t5_restart_run", running, 1);
    chk("t5_restart_clk", clk_out, 1);
    cyc();
    enable = 1'b0;
    cyc();
    cyc();
    cyc();
    enable = 1'b1;
    v5b_clk  = 5'b01110;
    v5b_tick = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t5b_clk", clk_out, v5b_clk[4-i]);
      chk("t5b_tick", tick, v5b_tick[4-i]);
      chk("t5b_run", running, 1);
    end

    // 6: asynchronous reset in the high phase, then duty measurement at N=5
    sync_tick();
    cyc();
    chk("t6_pre_rst_clk", clk_out, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_clk", clk_out, 0);
    chk("t6_async_run", running, 0);
    chk("t6_async_div", div_active, 2);
    #1 rst = 1'b0;
    div_load = 1'b1; div_value = 16'd5; enable = 1'b1;
    cyc();
    div_load = 1'b0;
    chk("t6_stopped_ack", div_ack, 1);
    chk("t6_stopped_div", div_active, 5);
    chk("t6_start_clk", clk_out, 1);
    t0 = -1; t1 = -1;
    fork
      begin
        @(posedge clk_out);
        t0 = $time;
        @(negedge clk_out);
        t1 = $time;
      end
      begin
        #500;
      end
    join_any
    disable fork;
`ifdef CLKDIV_ODD_DUTY50_EN
    chk("t6_high_time", 32'(t1 - t0), 25);
`else
    chk("t6_high_time", 32'(t1 - t0), 20);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
